// File: rtl/desc_rot_scan_ctrl_if.sv
// Keypoint, ROM-bank and sample-stream signals of the descriptor rotation scan controller.
// slave: controller view; master: surrounding datapath / test environment view.
interface desc_rot_scan_ctrl_if;
    logic       kp_valid;
    logic       kp_ready;
    logic [5:0] kp_ori;
    logic [5:0] rom_sel;
    logic [7:0] rom_addr;
    logic [4:0] rom_dx;
    logic [4:0] rom_dy;
    logic       smp_valid;
    logic       smp_ready;
    logic [4:0] smp_dx;
    logic [4:0] smp_dy;
    logic [7:0] smp_idx;
    logic       scan_done;
    logic       busy;

    modport slave (
        input  kp_valid, kp_ori, rom_dx, rom_dy, smp_ready,
        output kp_ready, rom_sel, rom_addr, smp_valid, smp_dx, smp_dy, smp_idx,
               scan_done, busy
    );

    modport master (
        output kp_valid, kp_ori, rom_dx, rom_dy, smp_ready,
        input  kp_ready, rom_sel, rom_addr, smp_valid, smp_dx, smp_dy, smp_idx,
               scan_done, busy
    );
endinterface

// File: rtl/desc_rot_scan_ctrl.sv
// Descriptor-rotation ROM scan sequencer: per keypoint, raster-scans the selected ROM pair
// into a registered valid/ready sample stream. Optional macro DESC_ROT_CLIP_EN drops out-of-range offsets.
module desc_rot_scan_ctrl #(
    parameter int ORI_BINS = 36,
    parameter int WIN_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    desc_rot_scan_ctrl_if.slave  bus
);
    localparam logic [7:0] ADDR_LAST = 8'((2 ** (2 * WIN_BITS)) - 1);
    localparam logic [5:0] BINS      = 6'(ORI_BINS);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_e;

`ifdef DESC_ROT_CLIP_EN
    // A 5-bit offset fits the 4-bit range [-8,7] when its top two bits agree.
    function automatic logic in_range(input logic [4:0] v);
        return (v[4] == v[3]);
    endfunction
`endif

    state_e     state_q, state_d;
    logic       warm_q, warm_d;
    logic [5:0] sel_q, sel_d;
    logic [7:0] addr_q, addr_d;
    logic       vld_q, vld_d;
    logic [4:0] dx_q, dx_d;
    logic [4:0] dy_q, dy_d;
    logic [7:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic       kp_ready_q, kp_ready_d;
    logic       busy_q, busy_d;
    logic       ld_s;
    logic       keep_s;

    // Position filter: in the clipping build, out-of-range offsets are skipped.
    always_comb begin
`ifdef DESC_ROT_CLIP_EN
        keep_s = in_range(bus.rom_dx) && in_range(bus.rom_dy);
`else
        keep_s = 1'b1;
`endif
    end

    // Next-state and datapath control for the scan FSM.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ld_s    = !vld_q || bus.smp_ready;

        case (state_q)
            IDLE: begin
                if (bus.kp_valid) begin
                    sel_d   = (bus.kp_ori >= BINS) ? (bus.kp_ori - BINS) : bus.kp_ori;
                    addr_d  = 8'd0;
                    warm_d  = 1'b1;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                // First SCAN cycle lets the newly selected ROM pair settle before loading.
                if (warm_q) begin
                    warm_d = 1'b0;
                end else if (ld_s) begin
                    if (keep_s) begin
                        dx_d  = bus.rom_dx;
                        dy_d  = bus.rom_dy;
                        idx_d = addr_q;
                        vld_d = 1'b1;
                    end else begin
                        vld_d = 1'b0;
                    end
                    if (addr_q == ADDR_LAST) begin
                        if (keep_s) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 8'd1;
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            DRAIN: begin
                if (vld_q && bus.smp_ready) begin
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (!vld_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                warm_d  = 1'b0;
            end
        endcase

        kp_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            warm_q     <= 1'b0;
            sel_q      <= 6'd0;
            addr_q     <= 8'd0;
            vld_q      <= 1'b0;
            dx_q       <= 5'd0;
            dy_q       <= 5'd0;
            idx_q      <= 8'd0;
            done_q     <= 1'b0;
            kp_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_q     <= warm_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            kp_ready_q <= kp_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.kp_ready  = kp_ready_q;
    assign bus.rom_sel   = sel_q;
    assign bus.rom_addr  = addr_q;
    assign bus.smp_valid = vld_q;
    assign bus.smp_dx    = dx_q;
    assign bus.smp_dy    = dy_q;
    assign bus.smp_idx   = idx_q;
    assign bus.scan_done = done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_desc_rot_scan_ctrl.sv
// Directed bench for desc_rot_scan_ctrl with a stub ROM (dx = addr[4:0], dy = sel[4:0]).
module tb_desc_rot_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    desc_rot_scan_ctrl_if bus();

    desc_rot_scan_ctrl #(.ORI_BINS(36), .WIN_BITS(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    assign bus.rom_dx = bus.rom_addr[4:0];
    assign bus.rom_dy = bus.rom_sel[4:0];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected emission of a window position for the stub ROM.
    function automatic bit kept(input int i, input logic [5:0] sel);
`ifdef DESC_ROT_CLIP_EN
        logic [4:0] d;
        logic [4:0] s;
        d = i[4:0];
        s = sel[4:0];
        return (d[4] == d[3]) && (s[4] == s[3]);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int next_kept(input int i, input logic [5:0] sel);
        int j;
        j = i;
        while (j < 256 && !kept(j, sel)) j++;
        return j;
    endfunction

    function automatic int kept_count(input logic [5:0] sel);
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) if (kept(i, sel)) n++;
        return n;
    endfunction

    // Accepts one keypoint and follows the scan until scan_done, checking stream content.
    task automatic run_scan(input logic [5:0] ori, input bit toggle, input logic [5:0] exp_sel,
                            output int n_smp, output int first_cyc, output int done_cyc,
                            output int n_done);
        int cyc, exp_i, sel_err, hold_err, seq_err;
        logic pv, pr;
        logic [7:0] pidx;
        logic [4:0] pdx, pdy;
        n_smp = 0; first_cyc = -1; done_cyc = -1; n_done = 0;
        sel_err = 0; hold_err = 0; seq_err = 0;
        pv = 1'b0; pr = 1'b1; pidx = 8'd0; pdx = 5'd0; pdy = 5'd0;
        exp_i = next_kept(0, exp_sel);
        bus.kp_ori = ori;
        bus.kp_valid = 1'b1;
        bus.smp_ready = 1'b1;
        tick();
        bus.kp_valid = 1'b0;
        cyc = 0;
        while (cyc < 1200 && done_cyc < 0) begin
            tick();
            cyc++;
            if (bus.rom_sel !== exp_sel) sel_err++;
            if (pv && !pr && (bus.smp_valid !== 1'b1 || bus.smp_idx !== pidx ||
                              bus.smp_dx !== pdx || bus.smp_dy !== pdy)) hold_err++;
            if (bus.scan_done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (toggle) bus.smp_ready = ~bus.smp_ready;
            if (bus.smp_valid === 1'b1 && bus.smp_ready === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (bus.smp_idx !== 8'(exp_i) || bus.smp_dx !== 5'(exp_i) ||
                    bus.smp_dy !== exp_sel[4:0]) seq_err++;
                n_smp++;
                exp_i = next_kept(exp_i + 1, exp_sel);
            end
            pv = bus.smp_valid; pr = bus.smp_ready;
            pidx = bus.smp_idx; pdx = bus.smp_dx; pdy = bus.smp_dy;
        end
        bus.smp_ready = 1'b1;
        tick();
        if (bus.scan_done === 1'b1) n_done++;
        tests_run += 3;
        if (sel_err != 0) begin
            tests_failed++;
            $display("FAIL rom_sel_stable ori=%0d: %0d cycles wrong, required %0d", ori, sel_err, exp_sel);
        end
        if (hold_err != 0) begin
            tests_failed++;
            $display("FAIL stall_hold ori=%0d: %0d unstable cycles, required 0", ori, hold_err);
        end
        if (seq_err != 0) begin
            tests_failed++;
            $display("FAIL sample_seq ori=%0d: %0d bad samples, required 0", ori, seq_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.kp_valid = 1'b0; bus.kp_ori = 6'd0; bus.smp_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        tests_run += 5;
        if (bus.kp_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_kp_ready got %b want 1", bus.kp_ready); end
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        if (bus.smp_valid !== 1'b0 || bus.scan_done !== 1'b0) begin
            tests_failed++; $display("FAIL rst_valid_done got %b%b want 00", bus.smp_valid, bus.scan_done);
        end
        if (bus.rom_sel !== 6'd0 || bus.rom_addr !== 8'd0) begin
            tests_failed++; $display("FAIL rst_rom got sel=%0d addr=%0d want 0 0", bus.rom_sel, bus.rom_addr);
        end
        if (bus.smp_dx !== 5'd0 || bus.smp_dy !== 5'd0 || bus.smp_idx !== 8'd0) begin
            tests_failed++; $display("FAIL rst_smp got %0d %0d %0d want 0 0 0", bus.smp_dx, bus.smp_dy, bus.smp_idx);
        end
    endtask

    task automatic test_full_scan();
        int n, f, d, nd, ef, ed;
        run_scan(6'd15, 1'b0, 6'd15, n, f, d, nd);
        ef = (kept_count(6'd15) > 0) ? 2 + next_kept(0, 6'd15) : -1;
        ed = kept(255, 6'd15) ? 258 : 257;
        tests_run += 5;
        if (n != kept_count(6'd15)) begin tests_failed++; $display("FAIL full_count got %0d want %0d", n, kept_count(6'd15)); end
        if (f != ef) begin tests_failed++; $display("FAIL full_first_cycle got %0d want %0d", f, ef); end
        if (d != ed) begin tests_failed++; $display("FAIL full_done_cycle got %0d want %0d", d, ed); end
        if (nd != 1) begin tests_failed++; $display("FAIL full_done_pulses got %0d want 1", nd); end
        if (bus.kp_ready !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL full_idle got ready=%b busy=%b want 1 0", bus.kp_ready, bus.busy);
        end
    endtask

    task automatic test_stall();
        int n, f, d, nd;
        run_scan(6'd3, 1'b1, 6'd3, n, f, d, nd);
        tests_run += 2;
        if (n != kept_count(6'd3)) begin tests_failed++; $display("FAIL stall_count got %0d want %0d", n, kept_count(6'd3)); end
        if (nd != 1) begin tests_failed++; $display("FAIL stall_done_pulses got %0d want 1", nd); end
    endtask

    task automatic test_ori_wrap();
        int n, f, d, nd;
        run_scan(6'd40, 1'b0, 6'd4, n, f, d, nd);
        tests_run += 1;
        if (n != kept_count(6'd4)) begin tests_failed++; $display("FAIL wrap40_count got %0d want %0d", n, kept_count(6'd4)); end
        run_scan(6'd63, 1'b0, 6'd27, n, f, d, nd);
        tests_run += 1;
        if (n != kept_count(6'd27)) begin tests_failed++; $display("FAIL wrap63_count got %0d want %0d", n, kept_count(6'd27)); end
    endtask

    task automatic test_reset_mid();
        int n, f, d, nd, c;
        bit hit;
        bus.kp_ori = 6'd5; bus.kp_valid = 1'b1; bus.smp_ready = 1'b1;
        tick();
        bus.kp_valid = 1'b0;
        hit = 1'b0;
        c = 0;
        while (c < 400 && !hit) begin
            tick();
            c++;
            hit = (bus.smp_valid === 1'b1 && bus.smp_idx === 8'd100);
        end
        tests_run += 1;
        if (!hit) begin tests_failed++; $display("FAIL mid_reach_idx100 got none within %0d cycles want idx 100", c); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run += 2;
        if (bus.smp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.kp_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_state got v=%b busy=%b rdy=%b want 0 0 1", bus.smp_valid, bus.busy, bus.kp_ready);
        end
        if (bus.scan_done !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_done got %b want 0", bus.scan_done); end
        tick();
        tests_run += 1;
        if (bus.scan_done !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL mid_after_reset got done=%b busy=%b want 0 0", bus.scan_done, bus.busy);
        end
        run_scan(6'd5, 1'b0, 6'd5, n, f, d, nd);
        tests_run += 1;
        if (f != 2 + next_kept(0, 6'd5)) begin tests_failed++; $display("FAIL mid_restart_first got %0d want %0d", f, 2 + next_kept(0, 6'd5)); end
    endtask

    task automatic test_back_to_back();
        int c;
        bit done_seen;
        bus.kp_ori = 6'd7; bus.kp_valid = 1'b1; bus.smp_ready = 1'b1;
        tick();
        bus.kp_ori = 6'd42;
        done_seen = 1'b0;
        c = 0;
        while (c < 600 && !done_seen) begin
            tick();
            c++;
            done_seen = (bus.scan_done === 1'b1);
        end
        tests_run += 2;
        if (c != 258 || !done_seen) begin tests_failed++; $display("FAIL b2b_first_done got cycle %0d want 258", c); end
        if (bus.kp_ready !== 1'b1 || bus.rom_sel !== 6'd7) begin
            tests_failed++; $display("FAIL b2b_ready_sel got rdy=%b sel=%0d want 1 7", bus.kp_ready, bus.rom_sel);
        end
        tick();
        tests_run += 1;
        if (bus.rom_sel !== 6'd6 || bus.busy !== 1'b1 || bus.kp_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept got sel=%0d busy=%b rdy=%b want 6 1 0", bus.rom_sel, bus.busy, bus.kp_ready);
        end
        bus.kp_valid = 1'b0;
        tick();
        tests_run += 1;
        if (bus.smp_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_warm got valid=%b want 0", bus.smp_valid); end
        tick();
        tests_run += 1;
        if (bus.smp_valid !== 1'b1 || bus.smp_idx !== 8'd0 || bus.smp_dy !== 5'd6) begin
            tests_failed++;
            $display("FAIL b2b_first_smp got v=%b idx=%0d dy=%0d want 1 0 6", bus.smp_valid, bus.smp_idx, bus.smp_dy);
        end
        done_seen = 1'b0;
        c = 0;
        while (c < 600 && !done_seen) begin
            tick();
            c++;
            done_seen = (bus.scan_done === 1'b1);
        end
        tests_run += 1;
        if (!done_seen) begin tests_failed++; $display("FAIL b2b_second_done got none want pulse"); end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_stall();
        test_ori_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
